// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - AXI4-Lite initiator for a single-outstanding core load/store port
//
// Purpose: accepts one core request at a time (req_*), runs it as an AXI4-Lite
// read (AR/R) or write (AW/W/B) transaction, then pulses resp_valid for one cycle.
// Ports:
//   clk, rst (async, active-low)
//   core side : req_valid/req_ready/req_wen/req_addr/req_wdata/req_wstrb,
//               resp_valid/resp_rdata/resp_err
//   bus side  : io_master_ar*, io_master_r*, io_master_aw*, io_master_w*, io_master_b*
module axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                io_master_arvalid,
    input  logic                io_master_arready,
    output logic [ADDR_W-1:0]   io_master_araddr,
    input  logic                io_master_rvalid,
    output logic                io_master_rready,
    input  logic [DATA_W-1:0]   io_master_rdata,
    input  logic [1:0]          io_master_rresp,
    output logic                io_master_awvalid,
    input  logic                io_master_awready,
    output logic [ADDR_W-1:0]   io_master_awaddr,
    output logic                io_master_wvalid,
    input  logic                io_master_wready,
    output logic [DATA_W-1:0]   io_master_wdata,
    output logic [DATA_W/8-1:0] io_master_wstrb,
    input  logic                io_master_bvalid,
    output logic                io_master_bready,
    input  logic [1:0]          io_master_bresp
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done;
    logic                w_done;

    // All bus payloads come from registers captured at accept, so they stay
    // stable for as long as the matching valid is high.
    assign io_master_araddr = addr_q;
    assign io_master_awaddr = addr_q;
    assign io_master_wdata  = wdata_q;
    assign io_master_wstrb  = wstrb_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every handshake-side output is decoded from the registered state only,
    // which keeps req_ready and the valids free of combinational paths from the bus.
    always_comb begin
        state_nxt         = state;
        req_ready         = 1'b0;
        resp_valid        = 1'b0;
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_bready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = req_wen ? WR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                io_master_arvalid = 1'b1;
                if (io_master_arready) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                io_master_rready = 1'b1;
                if (io_master_rvalid) begin
                    state_nxt = RESP;
                end
            end
            WR: begin
                io_master_awvalid = !aw_done;
                io_master_wvalid  = !w_done;
                // Leave once each channel has either finished earlier or is
                // handshaking now; both may complete in the same cycle.
                if ((aw_done || io_master_awready) && (w_done || io_master_wready)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                io_master_bready = 1'b1;
                if (io_master_bvalid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (io_master_awvalid && io_master_awready) begin
                aw_done <= 1'b1;
            end
            if (io_master_wvalid && io_master_wready) begin
                w_done <= 1'b1;
            end
            if (io_master_rready && io_master_rvalid) begin
                resp_rdata <= io_master_rdata;
                resp_err   <= (io_master_rresp != 2'b00);
            end
            if (io_master_bready && io_master_bvalid) begin
                resp_rdata <= '0;
                resp_err   <= (io_master_bresp != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - randomized self-checking bench for axi_lite_master
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [1:0]  bresp = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_cnt = 0;

    // slave behaviour for the current transaction
    int          cfg_ar_dly = 0;
    int          cfg_r_dly = 0;
    int          cfg_aw_dly = 0;
    int          cfg_w_dly = 0;
    int          cfg_b_dly = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = '0;
    logic [1:0]  cfg_bresp = '0;

    // expectations for the current / previous transaction
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    logic [3:0]  cur_wstrb = '0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    int          prev_resp_cyc = -1;
    logic        mon_ar_hs = 1'b0;
    logic        mon_aw_hs = 1'b0;
    logic        mon_w_hs = 1'b0;
    logic        prev_rv = 1'b0;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
        .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rdata(rdata),
        .io_master_rresp(rresp),
        .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
        .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
        .io_master_wstrb(wstrb),
        .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- slave model: one process per channel ----------------
    initial forever begin
        @(negedge clk);
        if (arvalid) begin
            repeat (cfg_ar_dly) @(negedge clk);
            arready = 1'b1;
            @(negedge clk);
            arready = 1'b0;
        end
    end

    // rvalid delay counts from the first arvalid, so it may precede arready
    initial forever begin
        @(negedge clk);
        if (arvalid) begin
            for (int i = 0; i < cfg_r_dly; i++) begin
                rdata = $urandom;
                @(negedge clk);
            end
            rvalid = 1'b1;
            rdata  = cfg_rdata;
            rresp  = cfg_rresp;
            while (!rready && rst) @(negedge clk);
            @(negedge clk);
            rvalid = 1'b0;
            rdata  = $urandom;
            rresp  = 2'($urandom_range(3));
        end
    end

    initial forever begin
        @(negedge clk);
        if (awvalid) begin
            repeat (cfg_aw_dly) @(negedge clk);
            awready = 1'b1;
            @(negedge clk);
            awready = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (wvalid) begin
            repeat (cfg_w_dly) @(negedge clk);
            wready = 1'b1;
            @(negedge clk);
            wready = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (awvalid || wvalid) begin
            while (awvalid || wvalid) @(negedge clk);
            repeat (cfg_b_dly) @(negedge clk);
            bvalid = 1'b1;
            bresp  = cfg_bresp;
            while (!bready && rst) @(negedge clk);
            @(negedge clk);
            bvalid = 1'b0;
        end
    end

    // ---------------- bus protocol monitor ----------------
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (arvalid) begin
                check("araddr", araddr, cur_addr);
                check("ar_after_hs", 32'(mon_ar_hs), 32'd0);
            end
            if (rready) check("rready_before_ar", 32'(mon_ar_hs), 32'd1);
            if (awvalid) begin
                check("awaddr", awaddr, cur_addr);
                check("aw_after_hs", 32'(mon_aw_hs), 32'd0);
            end
            if (wvalid) begin
                check("wdata", wdata, cur_wdata);
                check("wstrb", 32'(wstrb), 32'(cur_wstrb));
                check("w_after_hs", 32'(mon_w_hs), 32'd0);
            end
            if (bready) check("bready_early", 32'(mon_aw_hs && mon_w_hs), 32'd1);
            if ((arvalid || rready) && (awvalid || wvalid || bready))
                check("rd_wr_exclusive", 32'd1, 32'd0);
            if (arvalid && arready) mon_ar_hs = 1'b1;
            if (awvalid && awready) mon_aw_hs = 1'b1;
            if (wvalid && wready) mon_w_hs = 1'b1;
            if (resp_valid) begin
                check("resp_pulse_width", 32'(prev_rv), 32'd0);
                resp_cnt = resp_cnt + 1;
            end
            prev_rv = resp_valid;
        end else begin
            prev_rv = 1'b0;
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic set_dly(input int ar, input int r, input int aw, input int w, input int b);
        cfg_ar_dly = ar;
        cfg_r_dly  = r;
        cfg_aw_dly = aw;
        cfg_w_dly  = w;
        cfg_b_dly  = b;
    endtask

    task automatic run_txn(input logic wen, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] rd, input logic [1:0] rr,
                           input logic [1:0] br, input bit chk_lat);
        int n;
        int acc;
        logic [31:0] exp_rd;
        logic        exp_err;
        check("hold_rdata", resp_rdata, last_rdata);
        check("hold_err", 32'(resp_err), 32'(last_err));
        cur_addr  = a;
        cur_wdata = d;
        cur_wstrb = s;
        cfg_rdata = rd;
        cfg_rresp = rr;
        cfg_bresp = br;
        mon_ar_hs = 1'b0;
        mon_aw_hs = 1'b0;
        mon_w_hs  = 1'b0;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", 32'(req_ready), 32'd1);
        acc = cyc;
        if (prev_resp_cyc >= 0) check("b2b_accept", 32'(acc), 32'(prev_resp_cyc + 1));
        @(negedge clk);
        // core inputs after acceptance must have no effect
        req_valid = 1'b0;
        req_wen   = ~wen;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        n = 0;
        while (!resp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("resp_seen", 32'(resp_valid), 32'd1);
        if (chk_lat) check("latency", 32'(cyc - acc), 32'd3);
        exp_rd  = wen ? 32'd0 : rd;
        exp_err = wen ? (br != 2'b00) : (rr != 2'b00);
        check(wen ? "wr_rdata" : "rd_rdata", resp_rdata, exp_rd);
        check(wen ? "wr_err" : "rd_err", 32'(resp_err), 32'(exp_err));
        last_rdata    = exp_rd;
        last_err      = exp_err;
        prev_resp_cyc = cyc;
    endtask

    initial begin
        int rc;
        logic [1:0] rr;
        logic [1:0] br;
        bit zw;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_valids", {28'd0, arvalid, awvalid, wvalid, 1'b0}, 32'd0);
        check("rst_readies", {30'd0, rready, bready}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        set_dly(2, 5, 0, 0, 0);
        run_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 2'b00, 1'b0);
        set_dly(0, 0, 3, 0, 1);
        run_txn(1'b1, 32'h8000_0020, 32'h1234_5678, 4'b0011, 32'h0, 2'b00, 2'b00, 1'b0);
        set_dly(0, 0, 0, 0, 0);
        run_txn(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00, 2'b00, 1'b1);
        run_txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h5A5A_0001, 2'b00, 2'b00, 1'b1);
        set_dly(1, 1, 1, 1, 1);
        run_txn(1'b0, 32'h1000_0000, 32'h0, 4'h0, 32'h0BAD_0BAD, 2'b10, 2'b00, 1'b0);
        run_txn(1'b1, 32'h1000_0004, 32'h7777_7777, 4'b1000, 32'h0, 2'b00, 2'b11, 1'b0);
        set_dly(3, 0, 0, 0, 0);
        run_txn(1'b0, 32'h2000_0040, 32'h0, 4'h0, 32'h1357_9BDF, 2'b00, 2'b00, 1'b0);

        // reset while the read address phase is stalled
        set_dly(10, 20, 0, 0, 0);
        cur_addr  = 32'h3000_0000;
        mon_ar_hs = 1'b0;
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h3000_0000;
        rc = 0;
        while (!req_ready && rc < 20) begin
            @(negedge clk);
            rc++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_arvalid", 32'(arvalid), 32'd1);
        rc = resp_cnt;
        #2 rst = 1'b0;
        #1;
        check("async_rst_arvalid", 32'(arvalid), 32'd0);
        check("async_rst_req_ready", 32'(req_ready), 32'd1);
        check("async_rst_rready", 32'(rready), 32'd0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        check("rst_no_resp", 32'(resp_cnt), 32'(rc));
        last_rdata    = 32'd0;
        last_err      = 1'b0;
        prev_resp_cyc = -1;
        set_dly(0, 2, 0, 0, 0);
        run_txn(1'b0, 32'h3000_0008, 32'h0, 4'h0, 32'hA5A5_5A5A, 2'b00, 2'b00, 1'b0);

        for (int k = 0; k < 40; k++) begin
            zw = ($urandom_range(3) == 0);
            if (zw) set_dly(0, 0, 0, 0, 0);
            else set_dly($urandom_range(3), $urandom_range(5), $urandom_range(3),
                         $urandom_range(3), $urandom_range(3));
            rr = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
            br = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, rr, br, zw);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI4-Lite initiator bridging the CPU's simple load/store request port (IFU/LSU side) onto the AXI-Lite bus that the memory-side slaves respond on.
- One outstanding transaction at a time.
- Drives AR/R for loads and AW/W/B for stores, then returns one response pulse to the core.
- Sits between the core pipeline and the SRAM/peripheral slaves (or the arbiter in front of them).

Parameters:
- ADDR_W, 32, address width of req_addr and AR/AW channels.
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  core request valid.
- req_ready  out  1  block idle and able to accept a request.
- req_wen  in  1  1 = write (store), 0 = read (load).
- req_addr  in  ADDR_W  request byte address.
- req_wdata  in  DATA_W  store data.
- req_wstrb  in  DATA_W/8  store byte enables.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  load data; 0 for writes.
- resp_err  out  1  1 if RRESP/BRESP was non-zero.
- io_master_arvalid  out  1  read address valid.
- io_master_arready  in  1  read address ready.
- io_master_araddr  out  ADDR_W  read address.
- io_master_rvalid  in  1  read data valid.
- io_master_rready  out  1  read data ready.
- io_master_rdata  in  DATA_W  read data.
- io_master_rresp  in  2  read response.
- io_master_awvalid  out  1  write address valid.
- io_master_awready  in  1  write address ready.
- io_master_awaddr  out  ADDR_W  write address.
- io_master_wvalid  out  1  write data valid.
- io_master_wready  in  1  write data ready.
- io_master_wdata  out  DATA_W  write data.
- io_master_wstrb  out  DATA_W/8  write strobes.
- io_master_bvalid  in  1  write response valid.
- io_master_bready  out  1  write response ready.
- io_master_bresp  in  2  write response.

Behaviour:

Reset and request acceptance
- Asynchronous active-low reset on clk.
- While rst=0: state=IDLE; all *valid/*ready outputs=0 except req_ready=1; address/data/strobe registers, resp_rdata=0; resp_err=0.
- Reset mid-transaction aborts immediately to IDLE. No completion is reported.
- req_ready=1 only in IDLE (registered state, not combinational on bus inputs).
- A request is accepted on req_valid & req_ready. At that point addr, wdata and wstrb are registered. Core inputs are ignored afterwards.

FSM states
- IDLE:
  - Accept with req_wen=0 -> RD_ADDR.
  - Accept with req_wen=1 -> WR.
- RD_ADDR:
  - arvalid=1, araddr=registered addr.
  - Stays until arready sampled 1, then -> RD_DATA.
  - arvalid is never withdrawn before its handshake; address is stable while valid.
- RD_DATA:
  - rready=1.
  - On rvalid: capture rdata into resp_rdata, set resp_err = (rresp != 0), -> RESP.
  - An rvalid arriving in RD_ADDR is not accepted (rready=0 there).
- WR:
  - awvalid and wvalid both asserted on entry.
  - Each drops independently the cycle after its own handshake (awvalid&awready, wvalid&wready). Track with aw_done/w_done flags.
  - Simultaneous handshakes in one cycle are legal.
  - When both are done -> WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: resp_err = (bresp != 0), resp_rdata=0, -> RESP.
  - bready is never asserted before both AW and W have completed.
- RESP:
  - resp_valid=1 for exactly one cycle, then -> IDLE.
  - No backpressure from the core.
  - resp_rdata/resp_err hold until the next completion.

Latency
- Zero-wait slave:
  - Read: request accept at cycle 0 -> arvalid cycle 1 -> rready cycle 2 -> resp_valid cycle 3.
  - Write: resp_valid at cycle 3 (AW/W cycle 1, B cycle 2).
- Back-to-back: next req_ready is the cycle after resp_valid.

Bus-side invariants (assertable)
- Any valid output, once high, stays high with stable payload until its handshake.
- At most one of the read/write channel groups is active.

Test Plan:
- Read OK: req addr=0x8000_0010, wen=0; slave arready after 2 cycles, rvalid 3 cycles later with rdata=0xDEAD_BEEF, rresp=0 -> exactly one resp_valid pulse, resp_rdata=0xDEAD_BEEF, resp_err=0; araddr stable throughout arvalid.
- Write, W before AW: req addr=0x8000_0020, wdata=0x1234_5678, wstrb=4'b0011; wready at cycle 1, awready at cycle 4, bvalid 2 cycles later with bresp=0 -> wvalid drops after cycle 1, awvalid held until cycle 4, bready only after cycle 4, resp_valid once, resp_err=0, resp_rdata=0.
- Zero-wait back-to-back: write then read with all slave readies tied 1 -> each resp_valid at accept+3; second req accepted the cycle after first resp_valid.
- Error response: read with rresp=2'b10, then write with bresp=2'b11 -> resp_err=1 on both completions; no hang.
- Reset mid-operation: rst=0 while in RD_ADDR with arvalid=1 -> arvalid=0 asynchronously, req_ready=1, no resp_valid; a new read after release completes normally.
- Early rvalid: slave drives rvalid=1 before arready -> rready stays 0 until the AR handshake; captured data is the value present in RD_DATA.
